// File: rtl/mips_defs.sv
// Shared MIPS M-stage definitions: memory opcodes, FSM state encoding and a
// decoded view of the memory operation consumed by the access unit and dm_align.
package mips_defs;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SB  = 6'b101000;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    typedef struct packed {
        logic ld;
        logic st;
        logic sz_b;
        logic sz_h;
        logic sz_w;
        logic sext;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [5:0] op);
        mem_op_t d;
        d = '0;
        case (op)
            LW:  begin d.ld = 1'b1; d.sz_w = 1'b1; end
            LH:  begin d.ld = 1'b1; d.sz_h = 1'b1; d.sext = 1'b1; end
            LHU: begin d.ld = 1'b1; d.sz_h = 1'b1; end
            LB:  begin d.ld = 1'b1; d.sz_b = 1'b1; d.sext = 1'b1; end
            LBU: begin d.ld = 1'b1; d.sz_b = 1'b1; end
            SW:  begin d.st = 1'b1; d.sz_w = 1'b1; end
            SH:  begin d.st = 1'b1; d.sz_h = 1'b1; end
            SB:  begin d.st = 1'b1; d.sz_b = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dm_align.sv
// Sub-word store packing, byte-enable generation, load extension and alignment check.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs in the same cycle.
module dm_align
    import mips_defs::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  a,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        if (op.sz_b) begin
            be = 4'b0001 << a;
            if (op.st) wdata = {4{rt[7:0]}};
        end else if (op.sz_h) begin
            be = a[1] ? 4'b1100 : 4'b0011;
            if (op.st) wdata = {2{rt[15:0]}};
        end else if (op.sz_w) begin
            be = 4'b1111;
            if (op.st) wdata = rt;
        end
    end

    always_comb begin
        case (a)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    end

    // Non-loads return zero so the W stage can take ldata unconditionally on ack.
    always_comb begin
        ldata = 32'h0;
        if (op.ld) begin
            if (op.sz_b)
                ldata = {{24{op.sext & byte_sel[7]}}, byte_sel};
            else if (op.sz_h)
                ldata = {{16{op.sext & half_sel[15]}}, half_sel};
            else
                ldata = rdata;
        end
    end

    assign misaligned = (op.sz_w & (a != 2'b00)) | (op.sz_h & a[0]);

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage memory access unit: req/ack data-memory handshake, results registered to W.
// Latency: non-memory ops 1 cycle; memory ops 1 + WAIT cycles up to and including ack.
// Backpressure: mem_halt stalls em_reg and earlier stages while an access is outstanding.
module m_mem_ctrl
    import mips_defs::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_instr,
    input  logic [31:0] m_aluResult,
    input  logic [31:0] m_grf_rt,
    output logic        mem_halt,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [31:0] w_pc,
    output logic [31:0] w_instr,
    output logic [31:0] w_aluResult,
    output logic [31:0] w_memData,
    output logic        w_valid,
    output logic        mem_err
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    logic [0:0]  state;
    logic [7:0]  wait_cnt;
    mem_op_t     dec;
    logic [3:0]  be;
    logic [31:0] ldata;
    logic        misaligned;
    logic        is_mem;
    logic        in_wait;
    logic        go;
    logic        timeout;

    assign dec    = decode_op(m_instr[31:26]);
    assign is_mem = dec.ld | dec.st;

    dm_align u_align (
        .op         (dec),
        .a          (m_aluResult[1:0]),
        .rt         (m_grf_rt),
        .rdata      (dm_rdata),
        .be         (be),
        .wdata      (dm_wdata),
        .ldata      (ldata),
        .misaligned (misaligned)
    );

    // Reset gates the combinational outputs so nothing escapes in the reset cycle.
    assign in_wait = ~reset & (state == WAIT);
    assign go      = ~reset & (state == IDLE) & is_mem & ~misaligned;
    assign timeout = in_wait & ~dm_ack & (wait_cnt == LAST_WAIT);

    assign dm_req   = in_wait;
    assign dm_we    = in_wait & dec.st;
    assign dm_be    = in_wait ? be : 4'b0000;
    assign dm_addr  = {m_aluResult[31:2], 2'b00};
    assign mem_halt = go | (in_wait & ~dm_ack & ~timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            w_pc        <= 32'h0;
            w_instr     <= 32'h0;
            w_aluResult <= 32'h0;
            w_memData   <= 32'h0;
            w_valid     <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            // Bubble by default; only a completing instruction overwrites it.
            w_pc        <= 32'h0;
            w_instr     <= 32'h0;
            w_aluResult <= 32'h0;
            w_memData   <= 32'h0;
            w_valid     <= 1'b0;
            mem_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        if (misaligned) begin
                            mem_err <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 8'd0;
                        end
                    end else begin
                        w_pc        <= m_pc;
                        w_instr     <= m_instr;
                        w_aluResult <= m_aluResult;
                        w_valid     <= 1'b1;
                    end
                end
                default: begin
                    if (dm_ack) begin
                        w_pc        <= m_pc;
                        w_instr     <= m_instr;
                        w_aluResult <= m_aluResult;
                        w_memData   <= ldata;
                        w_valid     <= 1'b1;
                        state       <= IDLE;
                    end else if (timeout) begin
                        mem_err  <= 1'b1;
                        state    <= IDLE;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Bench for m_mem_ctrl: directed scenarios then random memory/ALU instructions,
// checked cycle by cycle against an arithmetic model of the access rules.
module tb_m_mem_ctrl;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_pc, m_instr, m_aluResult, m_grf_rt;
    logic        mem_halt, dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_ack;
    logic [31:0] w_pc, w_instr, w_aluResult, w_memData;
    logic        w_valid, mem_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] pc = 32'h0040_0000;

    always #5 clk = ~clk;

    m_mem_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .m_pc(m_pc), .m_instr(m_instr), .m_aluResult(m_aluResult), .m_grf_rt(m_grf_rt),
        .mem_halt(mem_halt), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .w_pc(w_pc), .w_instr(w_instr), .w_aluResult(w_aluResult), .w_memData(w_memData),
        .w_valid(w_valid), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 = non-memory, 1 = load, 2 = store; size in bytes; sgn = sign-extending load
    task automatic classify(input logic [5:0] opc, output int kind, output int size, output bit sgn);
        kind = 0; size = 4; sgn = 0;
        case (opc)
            6'h23: begin kind = 1; size = 4; end
            6'h21: begin kind = 1; size = 2; sgn = 1; end
            6'h25: begin kind = 1; size = 2; end
            6'h20: begin kind = 1; size = 1; sgn = 1; end
            6'h24: begin kind = 1; size = 1; end
            6'h2b: begin kind = 2; size = 4; end
            6'h29: begin kind = 2; size = 2; end
            6'h28: begin kind = 2; size = 1; end
            default: kind = 0;
        endcase
    endtask

    // One instruction through M; ack arrives on WAIT cycle k (k outside 1..MAXW: never).
    task automatic run_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] rt,
                          input logic [31:0] rdata, input int k);
        int kind, size, sh;
        bit sgn, mis;
        logic [31:0] mask, ld, ewd, ebe, rtv;
        classify(instr[31:26], kind, size, sgn);
        mis  = (kind != 0) && ((a % size) != 0);
        rtv  = rt;
        sh   = (size == 1) ? 8 * (a % 4) : 8 * (a % 4 & 2);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        ld   = (rdata >> sh) & mask;
        if (sgn && ld[8 * size - 1]) ld = ld | ~mask;
        ebe  = (size == 4) ? 32'hF : ((size == 2) ? (32'd3 << (a % 4)) : (32'd1 << (a % 4)));
        ewd  = (size == 4) ? rtv : ((size == 2) ? rtv[15:0] * 32'h0001_0001 : rtv[7:0] * 32'h0101_0101);

        pc = pc + 32'd4;
        m_pc = pc; m_instr = instr; m_aluResult = a; m_grf_rt = rt; dm_rdata = rdata;
        dm_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_req", dm_req, 0);
        check("idle_halt", mem_halt, (kind != 0 && !mis));
        @(posedge clk); #1;
        dm_ack = 1'b0;
        if (kind == 0) begin
            check("alu_w_instr", w_instr, instr);
            check("alu_w_pc", w_pc, pc);
            check("alu_w_alu", w_aluResult, a);
            check("alu_w_mem", w_memData, 0);
            check("alu_w_valid", w_valid, 1);
            check("alu_err", mem_err, 0);
        end else if (mis) begin
            check("mis_w_valid", w_valid, 0);
            check("mis_w_instr", w_instr, 0);
            check("mis_err", mem_err, 1);
        end else begin
            check("issue_w_valid", w_valid, 0);
            check("issue_err", mem_err, 0);
            for (int i = 1; i <= MAXW; i++) begin
                dm_ack = (i == k);
                @(negedge clk);
                check("wait_req", dm_req, 1);
                check("wait_we", dm_we, (kind == 2));
                check("wait_be", dm_be, ebe);
                check("wait_addr", dm_addr, a & 32'hFFFF_FFFC);
                if (kind == 2) check("wait_wdata", dm_wdata, ewd);
                check("wait_halt", mem_halt, (i != k && i != MAXW));
                @(posedge clk); #1;
                if (i == k) begin
                    check("done_w_valid", w_valid, 1);
                    check("done_w_instr", w_instr, instr);
                    check("done_w_pc", w_pc, pc);
                    check("done_w_mem", w_memData, (kind == 1) ? ld : 32'h0);
                    check("done_err", mem_err, 0);
                    break;
                end else if (i == MAXW) begin
                    check("tmo_w_valid", w_valid, 0);
                    check("tmo_w_instr", w_instr, 0);
                    check("tmo_err", mem_err, 1);
                end else begin
                    check("wait_w_valid", w_valid, 0);
                end
            end
            dm_ack = 1'b0;
        end
    endtask

    initial begin
        logic [5:0] opcs [9];
        logic [5:0] opc;
        opcs = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2b, 6'h29, 6'h28, 6'h00};

        // Reset with a live store on the inputs: nothing may escape.
        reset = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h0;
        m_pc = 32'h0; m_instr = 32'hAC00_0000; m_aluResult = 32'h40; m_grf_rt = 32'h1;
        @(negedge clk);
        check("rst_req", dm_req, 0);
        check("rst_halt", mem_halt, 0);
        check("rst_be", dm_be, 0);
        @(posedge clk); #1;
        check("rst_w_valid", w_valid, 0);
        check("rst_w_instr", w_instr, 0);
        check("rst_err", mem_err, 0);
        reset = 1'b0; dm_ack = 1'b0;

        run_op(32'h0085_1021, 32'h0000_1234, 32'h0, 32'h0, 0);
        run_op(32'hA000_0010, 32'h0000_0006, 32'hAABB_CCDD, 32'h0, 1);          // sb
        run_op(32'h8000_0000, 32'h0000_0013, 32'h0, 32'h80FF_7F01, 3);          // lb
        run_op(32'h9000_0000, 32'h0000_0013, 32'h0, 32'h80FF_7F01, 3);          // lbu
        run_op(32'h8400_0000, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 2);          // lh
        run_op(32'h8C00_0000, 32'h0000_0006, 32'h0, 32'h0, 1);                  // lw misaligned
        run_op(32'hAC00_0000, 32'h0000_0020, 32'h1234_5678, 32'h0, MAXW);       // ack on last WAIT cycle
        run_op(32'h8C00_0000, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);          // timeout
        run_op(32'h0085_1021, 32'h0000_5678, 32'h0, 32'h0, 0);

        // Reset in the 2nd WAIT cycle; a later ack must be ignored.
        m_instr = 32'h8C00_0000; m_aluResult = 32'h200; dm_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rstw_req", dm_req, 0);
        check("rstw_halt", mem_halt, 0);
        @(posedge clk); #1;
        check("rstw_w_valid", w_valid, 0);
        reset = 1'b0; m_instr = 32'h0; m_aluResult = 32'h0; dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("late_ack_req", dm_req, 0);
        check("late_ack_halt", mem_halt, 0);
        @(posedge clk); #1;
        check("late_ack_w_valid", w_valid, 1);
        check("late_ack_w_mem", w_memData, 0);
        check("late_ack_err", mem_err, 0);
        dm_ack = 1'b0;

        for (int n = 0; n < 60; n++) begin
            opc = opcs[$urandom_range(0, 8)];
            run_op({opc, 26'($urandom)}, $urandom, $urandom, $urandom, int'($urandom_range(0, MAXW + 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
